// File: rtl/fifo_ctrl_1k.sv
// fifo_ctrl_1k: push/pop controller for an external 128x8 dual-port SRAM; define FIFO_ERR_FLAGS_EN for sticky overflow/underflow outputs
module fifo_ctrl_1k #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 7,
  parameter int AFULL_THRESH = 120
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  overflow,
  output logic                  underflow
`else
  input  logic [DATA_WIDTH-1:0] ram_dout
`endif
);
  localparam logic [ADDR_WIDTH:0] depth = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] afull = (ADDR_WIDTH+1)'(AFULL_THRESH);
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic push_acc, pop_acc;
  assign full        = count == depth;
  assign empty       = count == '0;
  assign almost_full = count >= afull;
  assign push_acc    = push & ~full;
  assign pop_acc     = pop & ~empty;
  assign ram_wen     = push_acc;
  assign ram_waddr   = wptr;
  assign ram_din     = push_data;
  assign ram_ren     = pop_acc;
  assign ram_raddr   = rptr;
  assign rd_data     = ram_dout;
  // pointers wrap naturally at DEPTH; rd_valid tracks the SRAM's one-cycle registered read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push_acc) wptr <= wptr + 1'b1;
      if (pop_acc) rptr <= rptr + 1'b1;
      count    <= (push_acc & ~pop_acc) ? count + 1'b1 : (pop_acc & ~push_acc) ? count - 1'b1 : count;
      rd_valid <= pop_acc;
    end
  end
`ifdef FIFO_ERR_FLAGS_EN
  // sticky error flags record any rejected request until the next reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (push & full);
      underflow <= underflow | (pop & empty);
    end
  end
`endif
endmodule
